// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its execution sequencer.
package instr_register_pkg;

  typedef enum logic [2:0] {
    ZERO  = 3'd0,
    PASSA = 3'd1,
    PASSB = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    MULT  = 3'd5,
    DIV   = 3'd6,
    MOD   = 3'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic [4:0]         address_t;
  typedef logic signed [63:0] result_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
    result_t  res;
  } instruction_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_EXEC = 3'd2,
    ST_OUT  = 3'd3,
    ST_FIN  = 3'd4
  } exec_state_t;

  function automatic result_t sext_operand(input operand_t op);
    return {{32{op[31]}}, op};
  endfunction

endpackage

// File: rtl/instr_alu.sv
// Combinational arithmetic for one instruction; 64-bit signed result.
module instr_alu
  import instr_register_pkg::*;
(
  input  opcode_t  opc,
  input  operand_t op_a,
  input  operand_t op_b,
  input  logic     div_en,
  output result_t  value,
  output logic     err
);

  result_t a;
  result_t b;
  result_t b_safe;
  logic    div_blocked;

  assign a           = sext_operand(op_a);
  assign b           = sext_operand(op_b);
  // A zero divisor never reaches the divider, so the unused quotient stays X-free.
  assign b_safe      = (b == 64'sd0) ? 64'sd1 : b;
  assign div_blocked = !div_en || (b == 64'sd0);

  // NOTE: every output gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    value = '0;
    err   = 1'b0;
    case (opc)
      ZERO:  value = '0;
      PASSA: value = a;
      PASSB: value = b;
      ADD:   value = a + b;
      SUB:   value = a - b;
      MULT:  value = a * b;
      DIV: begin
        if (div_blocked) err = 1'b1;
        else             value = a / b_safe;
      end
      MOD: begin
        if (div_blocked) err = 1'b1;
        else             value = a % b_safe;
      end
      default: value = '0;
    endcase
  end

endmodule

// File: rtl/instr_exec_seq.sv
// Walks a block of stored instructions, executes each one and streams
// the results out over a valid/ready handshake.
module instr_exec_seq
  import instr_register_pkg::*;
#(
  parameter int DIV_EN = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  address_t     start_addr,
  input  logic [5:0]   count,
  output address_t     read_pointer,
  input  instruction_t instruction_word,
  output logic         busy,
  output logic         done,
  output logic         res_valid,
  input  logic         res_ready,
  output address_t     res_addr,
  output opcode_t      res_opcode,
  output result_t      res_value,
  output logic         res_err
);

  exec_state_t state;
  logic [5:0]  remaining;
  opcode_t     cap_opc;
  operand_t    cap_a;
  operand_t    cap_b;
  result_t     alu_value;
  logic        alu_err;
  logic        unused_res;

  // The res field of the stored word is not consumed by this block.
  assign unused_res = ^instruction_word.res;

  instr_alu u_alu (
    .opc    (cap_opc),
    .op_a   (cap_a),
    .op_b   (cap_b),
    .div_en (DIV_EN != 0),
    .value  (alu_value),
    .err    (alu_err)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      remaining    <= '0;
      read_pointer <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      res_valid    <= 1'b0;
      res_addr     <= '0;
      res_opcode   <= ZERO;
      res_value    <= '0;
      res_err      <= 1'b0;
      cap_opc      <= ZERO;
      cap_a        <= '0;
      cap_b        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (count != 6'd0) begin
              read_pointer <= start_addr;
              remaining    <= count;
              busy         <= 1'b1;
              state        <= ST_READ;
            end else begin
              done  <= 1'b1;
              state <= ST_FIN;
            end
          end
        end
        ST_READ: begin
          cap_opc <= instruction_word.opc;
          cap_a   <= instruction_word.op_a;
          cap_b   <= instruction_word.op_b;
          state   <= ST_EXEC;
        end
        ST_EXEC: begin
          res_addr   <= read_pointer;
          res_opcode <= cap_opc;
          res_value  <= alu_value;
          res_err    <= alu_err;
          res_valid  <= 1'b1;
          state      <= ST_OUT;
        end
        ST_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            remaining <= remaining - 6'd1;
            if (remaining != 6'd1) begin
              // 5-bit pointer wraps 31 -> 0 naturally.
              read_pointer <= read_pointer + 5'd1;
              state        <= ST_READ;
            end else begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_FIN;
            end
          end
        end
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_exec_seq.sv
// Directed bench for instr_exec_seq: timing, arithmetic, wrap, stall, reset abort.
module tb_instr_exec_seq;
  import instr_register_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  address_t     start_addr;
  logic [5:0]   count;
  address_t     read_pointer;
  instruction_t instruction_word;
  logic         busy;
  logic         done;
  logic         res_valid;
  logic         res_ready;
  address_t     res_addr;
  opcode_t      res_opcode;
  result_t      res_value;
  logic         res_err;

  instruction_t instr_mem [32];
  assign instruction_word = instr_mem[read_pointer];

  instr_exec_seq #(.DIV_EN(1)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .start_addr       (start_addr),
    .count            (count),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .busy             (busy),
    .done             (done),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_addr         (res_addr),
    .res_opcode       (res_opcode),
    .res_value        (res_value),
    .res_err          (res_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    address_t addr;
    opcode_t  opc;
    result_t  value;
    logic     err;
  } beat_t;

  int    checks   = 0;
  int    failures = 0;
  beat_t beats[$];
  int    done_pulses;
  int    extra_valid;
  int    first_valid_cyc;
  int    last_hs_cyc;
  int    done_cyc;
  bit    finished;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic instruction_t mk(input opcode_t opc, input operand_t a, input operand_t b);
    instruction_t w;
    w.opc  = opc;
    w.op_a = a;
    w.op_b = b;
    w.res  = 64'sh0BAD_F00D_DEAD_BEEF;
    return w;
  endfunction

  function automatic logic [127:0] out_snapshot();
    return {55'd0, res_addr, res_opcode, res_value, res_err};
  endfunction

  // Runs one block, collecting handshaken beats; optional stall on one beat
  // and an optional start poke while busy.
  task automatic run_block(input address_t sa, input logic [5:0] cnt,
                           input int stall_beat, input int stall_len, input int poke_cyc);
    int cyc = 0;
    int stalled = 0;
    logic [127:0] snap = '0;
    beats.delete();
    done_pulses = 0; extra_valid = 0; first_valid_cyc = -1;
    last_hs_cyc = -1; done_cyc = -1; finished = 0;
    start = 1'b1; start_addr = sa; count = cnt; res_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!finished && cyc < 2000) begin
      start = (cyc == poke_cyc);
      if (start) begin
        start_addr = 5'd0;
        count      = 6'd3;
      end
      res_ready = 1'b1;
      if (res_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (beats.size() == stall_beat && stalled < stall_len) begin
          if (stalled == 0) snap = out_snapshot();
          else              check("stall_hold", out_snapshot(), snap);
          res_ready = 1'b0;
          stalled++;
        end else begin
          if (stalled > 0 && beats.size() == stall_beat) check("stall_release", out_snapshot(), snap);
          beats.push_back('{res_addr, res_opcode, res_value, res_err});
          last_hs_cyc = cyc;
        end
      end
      if (done) begin
        done_pulses++;
        done_cyc = cyc;
        finished = 1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; res_ready = 1'b1;
    check("no_timeout", 128'(finished), 128'd1);
    for (int i = 0; i < 4; i++) begin
      if (done)      done_pulses++;
      if (res_valid) extra_valid++;
      @(posedge clk); #1;
    end
    check("idle_busy", 128'(busy), 128'd0);
  endtask

  initial begin
    int     lat;
    int     post_done;
    result_t exp_v [6];
    logic    exp_e [6];

    reset_n = 1'b0; start = 1'b0; start_addr = '0; count = '0; res_ready = 1'b0;
    for (int i = 0; i < 32; i++) instr_mem[i] = mk(PASSA, operand_t'(i), 0);
    #12;
    check("reset_outputs", {res_valid, busy, done, read_pointer, out_snapshot()},
          {1'b0, 1'b0, 1'b0, 5'd0, 128'd0});
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single ADD, latency and done timing.
    instr_mem[3] = mk(ADD, 7, 5);
    run_block(5'd3, 6'd1, -1, 0, -1);
    check("add_nbeats", 128'(beats.size()), 128'd1);
    if (beats.size() >= 1) begin
      check("add_addr",  128'(beats[0].addr),  128'd3);
      check("add_opc",   128'(beats[0].opc),   128'(ADD));
      check("add_value", 128'(beats[0].value), 128'd12);
      check("add_err",   128'(beats[0].err),   128'd0);
    end
    check("first_valid_latency", 128'(first_valid_cyc), 128'd2);
    check("done_after_hs", 128'(done_cyc), 128'(last_hs_cyc + 1));
    check("add_done_pulses", 128'(done_pulses), 128'd1);

    // Signed arithmetic and zero divisor.
    instr_mem[10] = mk(SUB,  -15, 15);
    instr_mem[11] = mk(MULT, -15, 15);
    instr_mem[12] = mk(DIV,  -15, 4);
    instr_mem[13] = mk(MOD,  -15, 4);
    instr_mem[14] = mk(DIV,  9, 0);
    instr_mem[15] = mk(ADD,  32'sh8000_0000, -1);
    exp_v = '{-64'sd30, -64'sd225, -64'sd3, -64'sd3, 64'sd0, -64'sd2147483649};
    exp_e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    run_block(5'd10, 6'd6, -1, 0, -1);
    check("arith_nbeats", 128'(beats.size()), 128'd6);
    for (int i = 0; i < 6 && i < beats.size(); i++) begin
      check($sformatf("arith_value_%0d", i), 128'(beats[i].value), 128'(exp_v[i]));
      check($sformatf("arith_err_%0d", i),   128'(beats[i].err),   128'(exp_e[i]));
    end

    // Wrap-around with a 5-cycle stall on the second beat.
    for (int i = 0; i < 32; i++) instr_mem[i] = mk(PASSB, 0, 1000 + i);
    run_block(5'd30, 6'd4, 1, 5, -1);
    check("wrap_nbeats", 128'(beats.size()), 128'd4);
    for (int i = 0; i < 4 && i < beats.size(); i++) begin
      check($sformatf("wrap_addr_%0d", i), 128'(beats[i].addr), 128'((30 + i) % 32));
      check($sformatf("wrap_value_%0d", i), 128'(beats[i].value), 128'(1000 + (30 + i) % 32));
    end
    check("wrap_done_pulses", 128'(done_pulses), 128'd1);

    // count = 0: done only.
    run_block(5'd7, 6'd0, -1, 0, -1);
    check("zero_nbeats", 128'(beats.size() + extra_valid), 128'd0);
    check("zero_done_pulses", 128'(done_pulses), 128'd1);

    // count = 32 from 5, start poked while busy.
    for (int i = 0; i < 32; i++) instr_mem[i] = mk(ADD, operand_t'(i), 100);
    run_block(5'd5, 6'd32, -1, 0, 10);
    check("full_nbeats", 128'(beats.size()), 128'd32);
    for (int i = 0; i < 32 && i < beats.size(); i++) begin
      check($sformatf("full_addr_%0d", i),  128'(beats[i].addr),  128'((5 + i) % 32));
      check($sformatf("full_value_%0d", i), 128'(beats[i].value), 128'(100 + (5 + i) % 32));
    end
    check("full_done_pulses", 128'(done_pulses + extra_valid), 128'd1);

    // Reset asserted during OUT aborts the block.
    instr_mem[3] = mk(ADD, 7, 5);
    start = 1'b1; start_addr = 5'd3; count = 6'd2; res_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("abort_reached_out", 128'(res_valid), 128'd1);
    reset_n = 1'b0;
    #1;
    check("abort_outputs", {res_valid, busy, done, read_pointer, out_snapshot()},
          {1'b0, 1'b0, 1'b0, 5'd0, 128'd0});
    @(posedge clk); #1;
    reset_n = 1'b1;
    res_ready = 1'b1;
    post_done = 0;
    for (int i = 0; i < 8; i++) begin
      if (done || res_valid || busy) post_done++;
      @(posedge clk); #1;
    end
    check("abort_no_done", 128'(post_done), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_exec_seq.md
INSTR_EXEC_SEQ -- requirements
Module: instr_exec_seq

Interface
REQ-001 Parameter: DIV_EN, default 1, enables DIV/MOD evaluation; when 0, DIV/MOD yield 0 and assert res_err.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  single-cycle request to execute a block of stored instructions.
REQ-005 start_addr  input  address_t (5)  first register location to execute.
REQ-006 count  input  6  number of instructions to execute, 0..32.
REQ-007 read_pointer  output  address_t (5)  address driven to the instruction register.
REQ-008 instruction_word  input  instruction_t  combinational read data for read_pointer; fields opc, op_a, op_b, res.
REQ-009 busy  output  1  high from the accepted start until done.
REQ-010 done  output  1  one-cycle pulse when the block completes.
REQ-011 res_valid  output  1  result beat valid.
REQ-012 res_ready  input  1  downstream accepts the beat.
REQ-013 res_addr  output  address_t (5)  location the result came from.
REQ-014 res_opcode  output  opcode_t  executed opcode.
REQ-015 res_value  output  result_t (64, signed)  computed result.
REQ-016 res_err  output  1  divide/modulo by zero, or DIV/MOD with DIV_EN=0.

Function
REQ-017 FSM states: IDLE, READ, EXEC, OUT, FIN.
REQ-018 IDLE: start=1 with count>0 -> READ, latching start_addr into read_pointer and count into the remaining counter.
REQ-019 IDLE: start=1 with count=0 -> FIN, with no result beat.
REQ-020 READ: capture instruction_word into an internal register on the clock edge, then go to EXEC.
REQ-021 EXEC: compute the result from the captured word, register res_* outputs, set res_valid, then go to OUT.
REQ-022 Result rules, with operands sign-extended from operand_t (32-bit signed) to 64 bits:
- ZERO -> 0.
- PASSA -> a.
- PASSB -> b.
- ADD -> a+b.
- SUB -> a-b.
- MULT -> a*b (full 64-bit product).
- DIV -> a/b, truncating toward zero.
- MOD -> a%b, sign follows a.
REQ-023 DIV or MOD with b=0 -> res_value=0 and res_err=1; otherwise res_err=0.
REQ-024 OUT: hold all res_* outputs stable while res_valid=1 and res_ready=0.
REQ-025 OUT: on res_valid & res_ready, clear res_valid and decrement the remaining counter.
- Remaining count nonzero -> increment read_pointer, go to READ.
- Otherwise -> go to FIN.
REQ-026 read_pointer increments modulo 32, so 31 wraps to 0.
REQ-027 FIN: pulse done for one cycle, drop busy, return to IDLE.
REQ-028 start is ignored in every state except IDLE.
REQ-029 Minimum spacing between beats is 3 cycles; the first res_valid occurs 2 cycles after the accepted start.
REQ-030 The block never writes the instruction register; the res field of instruction_word is ignored.

Reset
REQ-031 While reset_n=0, state=IDLE and all outputs are 0: read_pointer=0, busy=0, done=0, res_valid=0, res_addr=0, res_opcode=ZERO, res_value=0, res_err=0.
REQ-032 Reset asserted mid-block aborts immediately; no done pulse is issued and the pending beat is discarded.

Structure
REQ-033 result_t (64-bit signed) and the FSM state enum are added to instr_register_pkg, alongside the existing opcode_t, operand_t, address_t and instruction_t.
REQ-034 The arithmetic is a combinational sub-module, instr_alu (inputs opc, op_a, op_b, div_en; outputs value, err), instantiated once.
REQ-035 The FSM, counter and output registers reside in instr_exec_seq.

Verification
REQ-036 Reset mid-block: reset_n=0 during OUT -> all outputs 0 next sample and no done pulse.
REQ-037 ADD and backpressure: location 3 = {ADD, 7, 5}, start_addr=3, count=1, res_ready=1 -> one beat {addr 3, ADD, 12, err 0}; done asserted 1 cycle after the handshake.
REQ-038 Wrap-around: start_addr=30, count=4, with res_ready held low 5 cycles on beat 2.
- Required order: res_addr 30, 31, 0, 1.
- Beat-2 outputs stable throughout the stall.
- Exactly 4 beats and one done pulse.
REQ-039 Signed arithmetic and zero divisor:
- {SUB, -15, 15} -> -30.
- {MULT, -15, 15} -> -225.
- {DIV, -15, 4} -> -3.
- {MOD, -15, 4} -> -3.
- {DIV, 9, 0} -> 0 with res_err=1.
REQ-040 Count edge cases: count=0 -> done pulse with no res_valid; count=32 from address 5 -> 32 beats covering every location once; start pulsed while busy -> ignored.
